// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: access-size encodings, the memory-stage
// state type, and small lane helpers used by the memory-access stage.
package mips_pkg;

  // Access size encodings presented by EX. Code 3 is reserved and behaves as a word.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    MEM_IDLE,
    MEM_REQ
  } mem_state_e;

  // Natural alignment check; bytes are always aligned.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    unique case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

  // Little-endian byte enables for the addressed lane(s).
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    unique case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate store data across every lane so memory can pick it with the byte enables.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] wd;
    unique case (size)
      SZ_BYTE: wd = {4{data[7:0]}};
      SZ_HALF: wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane extraction: picks the byte or halfword addressed within a read word
// and sign- or zero-extends it to 32 bits. Purely combinational so it can also
// sit behind a cache read path.
module load_extend
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        unsigned_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the addressed lanes, then extend according to the access size.
  always_comb begin
    byte_lane = rdata[7:0];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    unique case (addr_lo)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase

    unique case (size)
      SZ_BYTE: result = {{24{byte_lane[7] & ~unsigned_ext}}, byte_lane};
      SZ_HALF: result = {{16{half_lane[15] & ~unsigned_ext}}, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MIPS memory-access stage. Takes the EX result as an effective address, runs a
// req/ack transaction with data memory for loads and stores, steers store lanes,
// extends load lanes, and registers the writeback payload. EX is stalled for the
// whole time a memory request is outstanding.
module mem_access
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] exc_badvaddr
);

  mem_state_e  state;

  // Operation fields kept while the request is in flight.
  logic        lat_load;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic        lat_unsigned;
  logic [4:0]  lat_rd;
  logic        lat_reg_write;

  logic        is_mem;
  logic        is_load;
  logic        aligned;
  logic [31:0] ld_result;

  // Decode the presented instruction; a read wins when both read and write are set.
  always_comb begin
    is_mem  = ex_mem_read | ex_mem_write;
    is_load = ex_mem_read;
    aligned = is_aligned(ex_size, ex_addr[1:0]);
  end

  // Stall depends only on the state register.
  always_comb begin
    stall = (state == MEM_REQ);
  end

  // Extraction works on latched address bits, so only wb_data sees dm_rdata.
  load_extend u_load_extend (
    .rdata        (dm_rdata),
    .addr_lo      (lat_off),
    .size         (lat_size),
    .unsigned_ext (lat_unsigned),
    .result       (ld_result)
  );

  // Stage FSM with registered memory-port, writeback and exception outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= MEM_IDLE;
      lat_load      <= 1'b0;
      lat_size      <= SZ_BYTE;
      lat_off       <= 2'b00;
      lat_unsigned  <= 1'b0;
      lat_rd        <= 5'd0;
      lat_reg_write <= 1'b0;
      dm_req        <= 1'b0;
      dm_we         <= 1'b0;
      dm_addr       <= 32'd0;
      dm_be         <= 4'd0;
      dm_wdata      <= 32'd0;
      wb_valid      <= 1'b0;
      wb_data       <= 32'd0;
      wb_rd         <= 5'd0;
      wb_reg_write  <= 1'b0;
      exc_adel      <= 1'b0;
      exc_ades      <= 1'b0;
      exc_badvaddr  <= 32'd0;
    end else begin
      // Pulse outputs default low every cycle.
      wb_valid <= 1'b0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;

      unique case (state)
        MEM_IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              wb_valid     <= 1'b1;
              wb_data      <= ex_addr;
              wb_rd        <= ex_rd;
              wb_reg_write <= ex_reg_write;
            end else if (!aligned) begin
              // Faulting access never reaches memory; retire it with no register write.
              wb_valid     <= 1'b1;
              wb_data      <= ex_addr;
              wb_rd        <= ex_rd;
              wb_reg_write <= 1'b0;
              exc_adel     <= is_load;
              exc_ades     <= ~is_load;
              exc_badvaddr <= ex_addr;
            end else begin
              lat_load      <= is_load;
              lat_size      <= ex_size;
              lat_off       <= ex_addr[1:0];
              lat_unsigned  <= ex_unsigned;
              lat_rd        <= ex_rd;
              lat_reg_write <= ex_reg_write;
              dm_req        <= 1'b1;
              dm_we         <= ~is_load;
              dm_addr       <= {ex_addr[31:2], 2'b00};
              dm_be         <= lane_be(ex_size, ex_addr[1:0]);
              dm_wdata      <= is_load ? 32'd0 : lane_wdata(ex_size, ex_wdata);
              state         <= MEM_REQ;
            end
          end
        end

        MEM_REQ: begin
          if (dm_ack) begin
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            wb_valid     <= 1'b1;
            wb_rd        <= lat_rd;
            wb_reg_write <= lat_load & lat_reg_write;
            if (lat_load) begin
              wb_data <= ld_result;
            end
            state <= MEM_IDLE;
          end
        end

        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios followed by random
// instructions, all checked against a transaction-level reference model.
module tb_mem_access;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] exc_badvaddr;

  int errors = 0;
  int checks = 0;

  mem_access dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_size      (ex_size),
    .ex_unsigned  (ex_unsigned),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .stall        (stall),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_be        (dm_be),
    .dm_wdata     (dm_wdata),
    .dm_ack       (dm_ack),
    .dm_rdata     (dm_rdata),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .exc_adel     (exc_adel),
    .exc_ades     (exc_ades),
    .exc_badvaddr (exc_badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
  endfunction

  function automatic bit model_aligned(input logic [31:0] addr, input logic [1:0] size);
    return (addr % nbytes(size)) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] size);
    int n;
    int off;
    int mask;
    n    = nbytes(size);
    off  = (n == 4) ? 0 : int'(addr % 4);
    mask = ((1 << n) - 1) << off;
    return 4'(mask);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] data, input logic [1:0] size);
    int n;
    n = nbytes(size);
    if (n == 1) return (data & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (data & 32'hFFFF) * 32'h0001_0001;
    return data;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
    int n;
    logic [31:0] v;
    n = nbytes(size);
    if (n == 4) return rdata;
    v = rdata >> (8 * int'(addr % 4));
    if (n == 1) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    ex_valid     = 1'b0;
    ex_addr      = 32'd0;
    ex_wdata     = 32'd0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    ex_size      = 2'd0;
    ex_unsigned  = 1'b0;
    ex_rd        = 5'd0;
    ex_reg_write = 1'b0;
  endtask

  // Present one instruction from IDLE, serve it with ack after k REQ cycles, and check
  // every cycle of it. With junk set, random EX traffic is presented while stalled.
  task automatic run_op(input logic [31:0] addr, input logic [31:0] wdata, input logic rd_op,
                        input logic wr_op, input logic [1:0] size, input logic uns,
                        input logic [4:0] rd, input logic regw, input int k,
                        input logic [31:0] rdata, input bit junk);
    bit mem;
    bit al;
    mem = rd_op | wr_op;
    al  = model_aligned(addr, size);
    ex_valid     = 1'b1;
    ex_addr      = addr;
    ex_wdata     = wdata;
    ex_mem_read  = rd_op;
    ex_mem_write = wr_op;
    ex_size      = size;
    ex_unsigned  = uns;
    ex_rd        = rd;
    ex_reg_write = regw;
    tick();
    if (mem && al && junk) begin
      ex_valid = 1'b1;
      ex_addr  = $urandom;
      ex_mem_read = 1'($urandom_range(1));
      ex_rd    = 5'($urandom_range(31));
    end else begin
      ex_valid = 1'b0;
    end

    if (!mem) begin
      chk("pass_wb_valid", 32'(wb_valid), 32'd1);
      chk("pass_wb_data", wb_data, addr);
      chk("pass_wb_rd", 32'(wb_rd), 32'(rd));
      chk("pass_wb_reg_write", 32'(wb_reg_write), 32'(regw));
      chk("pass_stall", 32'(stall), 32'd0);
      chk("pass_dm_req", 32'(dm_req), 32'd0);
      tick();
      chk("pass_wb_pulse", 32'(wb_valid), 32'd0);
    end else if (!al) begin
      chk("mis_dm_req", 32'(dm_req), 32'd0);
      chk("mis_stall", 32'(stall), 32'd0);
      chk("mis_adel", 32'(exc_adel), 32'(rd_op));
      chk("mis_ades", 32'(exc_ades), 32'(!rd_op));
      chk("mis_badvaddr", exc_badvaddr, addr);
      chk("mis_wb_valid", 32'(wb_valid), 32'd1);
      chk("mis_wb_reg_write", 32'(wb_reg_write), 32'd0);
      tick();
      chk("mis_exc_pulse", 32'({exc_adel, exc_ades, wb_valid}), 32'd0);
    end else begin
      for (int c = 1; c <= k; c++) begin
        chk("req_stall", 32'(stall), 32'd1);
        chk("req_dm_req", 32'(dm_req), 32'd1);
        chk("req_dm_we", 32'(dm_we), 32'(!rd_op));
        chk("req_dm_addr", dm_addr, addr & 32'hFFFF_FFFC);
        chk("req_wb_valid", 32'(wb_valid), 32'd0);
        if (!rd_op) begin
          chk("req_dm_be", 32'(dm_be), 32'(model_be(addr, size)));
          chk("req_dm_wdata", dm_wdata, model_wdata(wdata, size));
        end
        dm_rdata = $urandom;
        if (c == k) begin
          dm_ack   = 1'b1;
          dm_rdata = rdata;
        end
        tick();
      end
      dm_ack   = 1'b0;
      ex_valid = 1'b0;
      chk("ack_wb_valid", 32'(wb_valid), 32'd1);
      chk("ack_dm_req", 32'(dm_req), 32'd0);
      chk("ack_stall", 32'(stall), 32'd0);
      chk("ack_wb_rd", 32'(wb_rd), 32'(rd));
      chk("ack_wb_reg_write", 32'(wb_reg_write), 32'(rd_op & regw));
      if (rd_op) chk("ack_wb_data", wb_data, model_load(rdata, addr, size, uns));
      tick();
      chk("ack_wb_pulse", 32'({wb_valid, dm_req, stall}), 32'd0);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n    = 1'b0;
    dm_ack   = 1'b0;
    dm_rdata = 32'd0;
    #2;
    chk("reset_outputs",
        32'({stall, dm_req, dm_we, dm_be, wb_valid, wb_rd, wb_reg_write, exc_adel, exc_ades}),
        32'd0);
    chk("reset_dm_addr", dm_addr | dm_wdata, 32'd0);
    chk("reset_wb_data", wb_data | exc_badvaddr, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Passthrough
    run_op(32'h0000_1234, 32'd0, 1'b0, 1'b0, 2'd2, 1'b0, 5'd5, 1'b1, 1, 32'd0, 1'b0);
    // lb / lbu at 0x103 with ack after 3 cycles
    run_op(32'h0000_0103, 32'd0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd3, 1'b1, 3, 32'h80FF_7F01, 1'b0);
    run_op(32'h0000_0103, 32'd0, 1'b1, 1'b0, 2'd0, 1'b1, 5'd4, 1'b1, 3, 32'h80FF_7F01, 1'b0);
    // sh at 0x202
    run_op(32'h0000_0202, 32'h0000_BEEF, 1'b0, 1'b1, 2'd1, 1'b0, 5'd0, 1'b0, 2, 32'd0, 1'b0);
    // Misaligned lw and sh
    run_op(32'h0000_0301, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd6, 1'b1, 1, 32'd0, 1'b0);
    run_op(32'h0000_0401, 32'h1234_5678, 1'b0, 1'b1, 2'd1, 1'b0, 5'd0, 1'b0, 1, 32'd0, 1'b0);

    // Reset while a request is outstanding
    ex_valid = 1'b1; ex_addr = 32'h0000_0600; ex_mem_read = 1'b1; ex_size = 2'd2;
    ex_rd = 5'd8; ex_reg_write = 1'b1;
    tick();
    ex_valid = 1'b0;
    chk("rst_pre_req", 32'(dm_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_drop", 32'({dm_req, stall, wb_valid}), 32'd0);
    tick();
    rst_n  = 1'b1;
    dm_ack = 1'b1;
    dm_rdata = 32'hDEAD_BEEF;
    tick();
    dm_ack = 1'b0;
    chk("rst_late_ack", 32'({wb_valid, dm_req, stall}), 32'd0);
    idle_inputs();

    // Back-to-back: lw, then add held by EX during the stall
    ex_valid = 1'b1; ex_addr = 32'h0000_0500; ex_mem_read = 1'b1; ex_size = 2'd2;
    ex_rd = 5'd7; ex_reg_write = 1'b1;
    tick();
    ex_addr = 32'h0000_ABCD; ex_mem_read = 1'b0; ex_rd = 5'd9;
    chk("b2b_stall", 32'(stall), 32'd1);
    dm_ack = 1'b1;
    dm_rdata = 32'h1122_3344;
    tick();
    dm_ack = 1'b0;
    chk("b2b_lw_valid", 32'(wb_valid), 32'd1);
    chk("b2b_lw_data", wb_data, 32'h1122_3344);
    chk("b2b_lw_rd", 32'(wb_rd), 32'd7);
    chk("b2b_stall_low", 32'(stall), 32'd0);
    tick();
    ex_valid = 1'b0;
    chk("b2b_add_valid", 32'(wb_valid), 32'd1);
    chk("b2b_add_data", wb_data, 32'h0000_ABCD);
    chk("b2b_add_rd", 32'(wb_rd), 32'd9);
    tick();
    chk("b2b_done", 32'(wb_valid), 32'd0);
    idle_inputs();

    // Random instructions, each followed by an idle cycle with a stray ack
    for (int i = 0; i < 60; i++) begin
      logic [1:0] kind;
      kind = 2'($urandom_range(3));
      run_op($urandom, $urandom, kind[0], kind[1], 2'($urandom_range(3)),
             1'($urandom_range(1)), 5'($urandom_range(31)), 1'($urandom_range(1)),
             int'($urandom_range(4, 1)), $urandom, bit'($urandom_range(1)));
      dm_ack = 1'($urandom_range(1));
      tick();
      dm_ack = 1'b0;
      chk("rand_idle", 32'({wb_valid, dm_req, stall}), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
